// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared definitions for the 7-segment scan driver: the hex font
//            (active-high lit pattern, bit6=a .. bit0=g), the all-unlit
//            pattern and a nibble-to-segment lookup helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // All segments unlit, expressed in the active-high sense.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index n holds the lit pattern of hex digit n. Listed from F down to 0
  // because the leftmost concatenation element lands at the top index.
  localparam logic [15:0][6:0] FONT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
    7'h1F, 7'h77, 7'h73, 7'h7F,   // b A 9 8
    7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
    7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return FONT[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_lz_mask.sv
`default_nettype none
// ============================================================================
// Module   : seg7_lz_mask
// Purpose  : Leading-zero blank mask. Bit k (k>0) is set when nibbles
//            k..NUM_DIGITS-1 of disp are all zero. Bit 0 is never set so a
//            zero value still shows a single "0".
// Ports    : disp  in  4*NUM_DIGITS  displayed value
//            mask  out NUM_DIGITS    1 = digit is a leading zero
// Revision : 1.0 - initial release
// ============================================================================
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] disp,
  output logic [NUM_DIGITS-1:0]   mask
);

  logic w_seen_nonzero;

  // Walk from the most significant digit downwards; once a non-zero nibble
  // has been seen, every lower digit is significant.
  always_comb begin
    mask           = '0;
    w_seen_nonzero = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_seen_nonzero = w_seen_nonzero | (disp[4*k +: 4] != 4'h0);
      mask[k]        = ~w_seen_nonzero;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed hex driver for a NUM_DIGITS common-anode
//            7-segment bank. One shared segment bus, one enable per digit.
//            New values are staged in a shadow register and committed only
//            at frame end, so a scan never mixes old and new digits.
//            Supports leading-zero blanking and whole-display blink.
// Ports    : clk         in  1             system clock
//            rst_n       in  1             synchronous active-low reset
//            value_in    in  4*NUM_DIGITS  value, nibble k -> digit k
//            load        in  1             strobe, captures value_in
//            blank_lz    in  1             leading-zero blanking enable
//            blink_en    in  1             blink enable
//            seg         out 7             segment bus, bit6=a .. bit0=g
//            an          out NUM_DIGITS    digit enables
//            frame_done  out 1             pulse after each full scan
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Pin-level "off" patterns after polarity is applied.
  localparam logic [6:0] SEG_DARK = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_DARK =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]          r_prescaler;
  logic [IDX_W-1:0]          r_digit_idx;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [4*NUM_DIGITS-1:0]   r_disp;
  logic                      r_pending;
  logic [BLK_W-1:0]          r_blink_cnt;
  logic                      r_blink_phase;

  logic                      w_slot_end;
  logic                      w_frame_end;
  logic [NUM_DIGITS-1:0]     w_lz_mask;
  logic [NUM_DIGITS-1:0]     w_an_sel;
  logic [3:0]                w_nib;
  logic [6:0]                w_seg_lit;
  logic [6:0]                w_seg_drv;
  logic [NUM_DIGITS-1:0]     w_an_drv;
  logic                      w_blank;

  assign w_slot_end  = (r_prescaler == PRE_LAST);
  assign w_frame_end = w_slot_end && (r_digit_idx == IDX_LAST);

  // ---------------------------------------------------------------- scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescaler <= '0;
      r_digit_idx <= '0;
      frame_done  <= 1'b0;
    end else begin
      r_prescaler <= w_slot_end ? '0 : r_prescaler + 1'b1;
      if (w_slot_end) begin
        r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end
      frame_done <= w_frame_end;
    end
  end

  // -------------------------------------------------------------- commit
  // The commit reads the pre-edge shadow; a load on the same edge then
  // overwrites shadow and re-arms pending (the later assignment wins), so
  // that value goes out at the following frame end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_frame_end && r_pending) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
      end
      if (load) begin
        r_shadow  <= value_in;
        r_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- blink
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------- output path
  seg7_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .disp (r_disp),
    .mask (w_lz_mask)
  );

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_an_sel
      assign w_an_sel[k] = (r_digit_idx == IDX_W'(k));
    end
  endgenerate

  assign w_nib     = r_disp[{r_digit_idx, 2'b00} +: 4];
  assign w_seg_lit = hex2seg(w_nib);
  assign w_seg_drv = (SEG_ACTIVE_LOW != 0) ? ~w_seg_lit : w_seg_lit;
  assign w_an_drv  = (AN_ACTIVE_LOW != 0) ? ~w_an_sel : w_an_sel;
  assign w_blank   = (blank_lz & w_lz_mask[r_digit_idx]) | (blink_en & r_blink_phase);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_DARK;
      an  <= AN_DARK;
    end else begin
      seg <= w_blank ? SEG_DARK : w_seg_drv;
      an  <= w_blank ? AN_DARK  : w_an_drv;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (4 digits, 4 clocks
//            per slot, 2 frames per blink half-period). A cycle-count based
//            reference model predicts seg/an/frame_done every cycle; directed
//            frames add literal expectations for the model-independent cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int CD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * CD;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .CLK_DIV        (CD),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Active-high lit patterns a..g for 0..F.
  logic [6:0] font_lit [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int          m_n;        // clock edges since reset
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  logic        m_pending;
  logic        m_valid = 1'b0;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_fd;

  always @(posedge clk) begin : model
    int          digit;
    int          phase;
    logic        blank;
    logic [3:0]  nib;
    if (!rst_n) begin
      m_n       = 0;
      m_shadow  = 16'h0;
      m_disp    = 16'h0;
      m_pending = 1'b0;
      exp_seg   = 7'h7F;
      exp_an    = 4'hF;
      exp_fd    = 1'b0;
      m_valid   = 1'b1;
    end else begin
      digit   = (m_n / CD) % ND;
      phase   = ((m_n / FRAME) / BF) % 2;
      nib     = 4'((m_disp >> (4 * digit)) & 16'hF);
      blank   = (blink_en && phase == 1) ||
                (blank_lz && digit > 0 && (m_disp >> (4 * digit)) == 16'h0);
      exp_seg = blank ? 7'h7F : ~font_lit[nib];
      exp_an  = blank ? 4'hF  : ~(4'b0001 << digit);
      exp_fd  = (((m_n + 1) % FRAME) == 0);
      if (exp_fd && m_pending) begin
        m_disp    = m_shadow;
        m_pending = 1'b0;
      end
      if (load) begin
        m_shadow  = value_in;
        m_pending = 1'b1;
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_an", 32'(an), 32'(exp_an));
      chk("model_frame_done", 32'(frame_done), 32'(exp_fd));
    end
  end

  // ----------------------------------------------------------- helpers
  task automatic count_to_fd(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 4 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Runs one frame starting at a frame_done negedge. Slot k is sampled two
  // cycles into its window; optional loads at given negedge offsets.
  task automatic run_frame(input bit lit, input logic [15:0] e_an, input logic [27:0] e_seg,
                           input int off1, input logic [15:0] v1,
                           input int off2, input logic [15:0] v2,
                           output logic [3:0] an0);
    int slot;
    an0 = 4'h0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == off1) begin load = 1'b1; value_in = v1; end
      if (i == off2) begin load = 1'b1; value_in = v2; end
      if ((i % CD) == 2) begin
        slot = i / CD;
        if (slot == 0) an0 = an;
        if (lit) begin
          chk($sformatf("slot%0d_an", slot), 32'(an), 32'(e_an[4*slot +: 4]));
          chk($sformatf("slot%0d_seg", slot), 32'(seg), 32'(e_seg[7*slot +: 7]));
        end
      end
    end
    chk("frame_done_period", 32'(frame_done), 32'd1);
  endtask

  localparam logic [15:0] AN_SCAN = {4'h7, 4'hB, 4'hD, 4'hE};
  localparam logic [15:0] AN_LZ0  = {4'hF, 4'hF, 4'hF, 4'hE};

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         cyc;
    int         dark;
    logic [3:0] an0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    count_to_fd(cyc);
    chk("first_fd_latency", 32'(cyc), 32'd16);
    count_to_fd(cyc);
    chk("fd_period", 32'(cyc), 32'd16);

    // Still zero; load 1A3F during the frame.
    run_frame(1'b1, AN_SCAN, {4{7'h01}}, 3, 16'h1A3F, -1, 16'h0, an0);
    // 1A3F shown; mid-frame load of 0005 must not tear it.
    run_frame(1'b1, AN_SCAN, {7'h4F, 7'h08, 7'h06, 7'h38}, 5, 16'h0005, -1, 16'h0, an0);
    // 0005 without blanking.
    run_frame(1'b1, AN_SCAN, {7'h01, 7'h01, 7'h01, 7'h24}, -1, 16'h0, -1, 16'h0, an0);
    blank_lz = 1'b1;
    run_frame(1'b1, AN_LZ0, {7'h7F, 7'h7F, 7'h7F, 7'h24}, 8, 16'h0000, -1, 16'h0, an0);
    // Zero with blanking shows one "0"; then 1111 pending, 2222 on the wrap.
    run_frame(1'b1, AN_LZ0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4, 16'h1111, 15, 16'h2222, an0);
    blank_lz = 1'b0;
    run_frame(1'b1, AN_SCAN, {4{7'h4F}}, -1, 16'h0, -1, 16'h0, an0);
    run_frame(1'b1, AN_SCAN, {4{7'h12}}, -1, 16'h0, -1, 16'h0, an0);

    // Blink: two of any four consecutive frames are dark.
    blink_en = 1'b1;
    dark = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, 16'h0, 28'h0, -1, 16'h0, -1, 16'h0, an0);
      if (an0 == 4'hF) dark++;
    end
    chk("blink_dark_frames", 32'(dark), 32'd2);
    blink_en = 1'b0;

    // Reset mid-slot with a load pending: everything is discarded.
    repeat (4) @(negedge clk);
    @(negedge clk);
    load = 1'b1; value_in = 16'hABCD;
    @(negedge clk);
    load = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_seg", 32'(seg), 32'h7F);
    chk("midreset_an", 32'(an), 32'hF);
    chk("midreset_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    count_to_fd(cyc);
    chk("post_reset_fd_latency", 32'(cyc), 32'd16);
    run_frame(1'b1, AN_SCAN, {4{7'h01}}, -1, 16'h0, -1, 16'h0, an0);
    run_frame(1'b1, AN_SCAN, {4{7'h01}}, -1, 16'h0, -1, 16'h0, an0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 63) == 0)  blank_lz = ~blank_lz;
      if ($urandom_range(0, 127) == 0) blink_en = ~blink_en;
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
